// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD write engine.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_EXEC
   } lcd_state_e;

   localparam int unsigned LCD_ON_BIT   = 31;
   localparam int unsigned LCD_BLON_BIT = 30;
   localparam int unsigned LCD_GO_BIT   = 29;
   localparam int unsigned LCD_RS_BIT   = 8;

   // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; zero_o is registered and tracks count == 0.
module lcd_timer #(
   parameter int unsigned W = 17
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic         zero_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else if (load_i) begin
         cnt_q  <= load_val_i;
         zero_q <= (load_val_i == '0);
      end else if (!zero_q) begin
         cnt_q  <= cnt_q - W'(1);
         zero_q <= (cnt_q == W'(1));
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/lcd_ctrl.sv
// Turns each toggle of the LSU LCD go bit into one timed HD44780 write cycle
// and exposes a busy/transfer-count status word.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC     = 2,
   parameter int unsigned EN_CYC        = 12,
   parameter int unsigned HOLD_CYC      = 2,
   parameter int unsigned EXEC_CYC      = 2000,
   parameter int unsigned LONG_EXEC_CYC = 80000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] io_lcd_i,
   output logic [7:0]  lcd_data_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic        lcd_on_o,
   output logic        lcd_blon_o,
   output logic        busy_o,
   output logic [31:0] status_o
);

   localparam int unsigned MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int unsigned MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
   localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAX_CYC = (MAX_C > LONG_EXEC_CYC) ? MAX_C : LONG_EXEC_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_EXEC_CYC - 1);

   lcd_state_e       state_q, state_d;
   logic             go_prev_q;
   logic [7:0]       data_q;
   logic             rs_q;
   logic             en_q;
   logic             busy_q;
   logic             on_q;
   logic             blon_q;
   logic [7:0]       done_cnt_q;

   logic             accept;
   logic             done_inc;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             unused_io;

   assign unused_io = ^io_lcd_i[LCD_GO_BIT-1:LCD_RS_BIT+1];

   lcd_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // Next-state logic; the timer is reloaded on every state entry.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      done_inc = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (io_lcd_i[LCD_GO_BIT] != go_prev_q) begin
               accept   = 1'b1;
               state_d  = ST_SETUP;
               tmr_load = 1'b1;
               tmr_val  = LD_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = LD_EN;
            end
         end
         ST_PULSE: begin
            if (tmr_zero) begin
               state_d  = ST_HOLD;
               tmr_load = 1'b1;
               tmr_val  = LD_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               state_d  = ST_EXEC;
               tmr_load = 1'b1;
               tmr_val  = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_EXEC;
            end
         end
         ST_EXEC: begin
            if (tmr_zero) begin
               state_d  = ST_IDLE;
               done_inc = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         go_prev_q  <= 1'b0;
         data_q     <= '0;
         rs_q       <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         on_q       <= 1'b0;
         blon_q     <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= (state_d == ST_PULSE);
         busy_q  <= (state_d != ST_IDLE);
         on_q    <= io_lcd_i[LCD_ON_BIT];
         blon_q  <= io_lcd_i[LCD_BLON_BIT];
         if (accept) begin
            go_prev_q <= io_lcd_i[LCD_GO_BIT];
            data_q    <= io_lcd_i[7:0];
            rs_q      <= io_lcd_i[LCD_RS_BIT];
         end
         if (done_inc) begin
            done_cnt_q <= done_cnt_q + 8'd1;
         end
      end
   end

   assign lcd_data_o = data_q;
   assign lcd_rs_o   = rs_q;
   assign lcd_rw_o   = 1'b0;
   assign lcd_en_o   = en_q;
   assign lcd_on_o   = on_q;
   assign lcd_blon_o = blon_q;
   assign busy_o     = busy_q;
   assign status_o   = {16'h0000, done_cnt_q, 7'b0000000, busy_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl; execution waits are shortened to keep run time small,
// setup/enable/hold use the default widths.
module tb_lcd_ctrl;

   localparam int unsigned TS  = 2;
   localparam int unsigned TE  = 12;
   localparam int unsigned TH  = 2;
   localparam int unsigned TX  = 20;
   localparam int unsigned TLX = 100;
   localparam int MAX_WAIT = TS + TE + TH + TLX + 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] io_lcd = '0;
   logic [7:0]  lcd_data;
   logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, lcd_busy;
   logic [31:0] status;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        go_v = 1'b0;
   logic        on_v = 1'b0;
   logic        blon_v = 1'b0;
   logic [7:0]  exp_cnt = 8'd0;

   always #5 clk = ~clk;

   lcd_ctrl #(
      .SETUP_CYC     (TS),
      .EN_CYC        (TE),
      .HOLD_CYC      (TH),
      .EXEC_CYC      (TX),
      .LONG_EXEC_CYC (TLX)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .io_lcd_i   (io_lcd),
      .lcd_data_o (lcd_data),
      .lcd_rs_o   (lcd_rs),
      .lcd_rw_o   (lcd_rw),
      .lcd_en_o   (lcd_en),
      .lcd_on_o   (lcd_on),
      .lcd_blon_o (lcd_blon),
      .busy_o     (lcd_busy),
      .status_o   (status)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_word(input logic rs, input logic [7:0] d);
      return {on_v, blon_v, go_v, 20'h00000, rs, d};
   endfunction

   function automatic logic [31:0] exp_status();
      return {16'h0000, exp_cnt, 8'h00};
   endfunction

   // Issue one request and measure it sample by sample on negedges.
   task automatic xfer(input string tag, input logic rs, input logic [7:0] d, input int flip_at,
                       output int busy_n, output int en_n, output int en_first, output int pulses);
      logic prev_en;
      bit   done;
      go_v     = ~go_v;
      io_lcd   = mk_word(rs, d);
      busy_n   = 0;
      en_n     = 0;
      en_first = -1;
      pulses   = 0;
      prev_en  = 1'b0;
      done     = 1'b0;
      for (int i = 0; i < MAX_WAIT && !done; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check_eq({tag, "_rs"}, 32'(lcd_rs), 32'(rs));
            check_eq({tag, "_data"}, 32'(lcd_data), 32'(d));
         end
         if (lcd_busy) busy_n++;
         else done = 1'b1;
         if (lcd_en) begin
            en_n++;
            if (en_first < 0) en_first = i;
            if (!prev_en) pulses++;
         end
         prev_en = lcd_en;
         if (flip_at >= 0 && i == flip_at + 1) begin
            check_eq({tag, "_on"}, 32'(lcd_on), 32'(on_v));
            check_eq({tag, "_blon"}, 32'(lcd_blon), 32'(blon_v));
         end
         if (i == flip_at) begin
            on_v   = ~on_v;
            blon_v = ~blon_v;
            io_lcd = mk_word(rs, d);
         end
      end
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      exp_cnt = exp_cnt + 8'd1;
   endtask

   task automatic wait_busy(input string tag, input logic val);
      bit hit = 1'b0;
      for (int i = 0; i < MAX_WAIT && !hit; i++) begin
         @(negedge clk);
         if (lcd_busy == val) hit = 1'b1;
      end
      check_eq({tag, "_wait"}, 32'(hit), 32'd1);
   endtask

   int b, e, f, p;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_en", 32'(lcd_en), 32'd0);
      check_eq("rst_busy", 32'(lcd_busy), 32'd0);
      check_eq("rst_status", status, 32'h0);
      check_eq("rst_data", {23'd0, lcd_rs, lcd_data}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single data write 0x2000_0141.
      xfer("wr41", 1'b1, 8'h41, -1, b, e, f, p);
      check_eq("wr41_busy", 32'(b), 32'(TS + TE + TH + TX));
      check_eq("wr41_en_len", 32'(e), 32'(TE));
      check_eq("wr41_en_start", 32'(f), 32'(TS));
      check_eq("wr41_pulses", 32'(p), 32'd1);
      check_eq("wr41_status", status, 32'h0000_0100);
      check_eq("wr41_rw", 32'(lcd_rw), 32'd0);

      // Data bus holds in IDLE when the word changes without a toggle.
      io_lcd = mk_word(1'b0, 8'hA5);
      repeat (4) @(negedge clk);
      check_eq("idle_hold", {23'd0, lcd_rs, lcd_data}, 32'h0000_0141);
      check_eq("idle_busy", 32'(lcd_busy), 32'd0);

      // Clear display uses the long wait.
      xfer("clr", 1'b0, 8'h01, -1, b, e, f, p);
      check_eq("clr_busy", 32'(b), 32'(TS + TE + TH + TLX));
      check_eq("clr_pulses", 32'(p), 32'd1);
      check_eq("clr_status", status, 32'h0000_0200);

      // Long-command predicate boundaries.
      xfer("home3", 1'b0, 8'h03, -1, b, e, f, p);
      check_eq("home3_busy", 32'(b), 32'(TS + TE + TH + TLX));
      xfer("cmd04", 1'b0, 8'h04, -1, b, e, f, p);
      check_eq("cmd04_busy", 32'(b), 32'(TS + TE + TH + TX));
      xfer("cmd00", 1'b0, 8'h00, -1, b, e, f, p);
      check_eq("cmd00_busy", 32'(b), 32'(TS + TE + TH + TX));
      xfer("dat01", 1'b1, 8'h01, -1, b, e, f, p);
      check_eq("dat01_busy", 32'(b), 32'(TS + TE + TH + TX));
      check_eq("short_status", status, exp_status());

      // Queued request: one toggle mid-EXEC starts exactly one cycle after IDLE.
      go_v   = ~go_v;
      io_lcd = mk_word(1'b1, 8'h30);
      repeat (TS + TE + TH + 3) @(negedge clk);
      check_eq("q_in_exec", {30'd0, lcd_en, lcd_busy}, 32'h1);
      go_v   = ~go_v;
      io_lcd = mk_word(1'b1, 8'h55);
      wait_busy("q_drop", 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      check_eq("q_idle_status", status, exp_status());
      @(negedge clk);
      check_eq("q_restart", 32'(lcd_busy), 32'd1);
      check_eq("q_data", {23'd0, lcd_rs, lcd_data}, 32'h0000_0155);
      wait_busy("q_end", 1'b0);
      exp_cnt = exp_cnt + 8'd1;

      // Double toggle mid-EXEC cancels out.
      go_v   = ~go_v;
      io_lcd = mk_word(1'b1, 8'h31);
      repeat (TS + TE + TH + 3) @(negedge clk);
      go_v   = ~go_v;
      io_lcd = mk_word(1'b1, 8'h31);
      @(negedge clk);
      go_v   = ~go_v;
      io_lcd = mk_word(1'b1, 8'h31);
      wait_busy("dt_drop", 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      repeat (5) @(negedge clk);
      check_eq("dt_no_second", 32'(lcd_busy), 32'd0);
      check_eq("dt_status", status, exp_status());

      // Reset mid-PULSE clears everything without a clock edge.
      go_v   = ~go_v;
      on_v   = 1'b1;
      io_lcd = mk_word(1'b1, 8'h77);
      repeat (TS + 3) @(negedge clk);
      check_eq("rp_en_high", 32'(lcd_en), 32'd1);
      check_eq("rp_on_high", 32'(lcd_on), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rp_en_low", 32'(lcd_en), 32'd0);
      check_eq("rp_outs", {21'd0, lcd_on, lcd_blon, lcd_rs, lcd_data}, 32'h0);
      check_eq("rp_status", status, 32'h0);
      go_v   = 1'b0;
      on_v   = 1'b0;
      blon_v = 1'b0;
      io_lcd = '0;
      exp_cnt = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rp_after_busy", 32'(lcd_busy), 32'd0);
      check_eq("rp_after_status", status, 32'h0);

      // Counter wrap over 256 transfers; first one flips on/backlight mid-PULSE.
      xfer("flip", 1'b1, 8'h20, TS + 4, b, e, f, p);
      check_eq("flip_en_len", 32'(e), 32'(TE));
      check_eq("flip_en_start", 32'(f), 32'(TS));
      for (int n = 1; n < 255; n++) begin
         xfer("wrap", 1'b1, 8'(n), -1, b, e, f, p);
      end
      check_eq("wrap_ff", status, 32'h0000_FF00);
      xfer("wrap_last", 1'b1, 8'hFF, -1, b, e, f, p);
      check_eq("wrap_zero", status, 32'h0000_0000);
      check_eq("wrap_on", {30'd0, lcd_on, lcd_blon}, 32'h3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
